// File: rtl/bp_me_nonsynth_lce_txn_monitor.sv
// Multi-LCE coherence transaction monitor for the BedRock LCE-CCE interface.
// Tracks outstanding LCE requests per LCE in a small table and ages each entry.
// Raises sticky protocol-violation flags and keeps global request/completion counters.
// Optional trace: define BP_ME_LCE_TXN_MONITOR_TRACE_EN to log table events.
module bp_me_nonsynth_lce_txn_monitor #(
  parameter int unsigned num_lce_p         = 2,
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned block_width_p     = 512,
  parameter int unsigned max_outstanding_p = 2,
  parameter int unsigned timeout_p         = 1024,
  parameter int unsigned ctr_width_p       = 32,
  localparam int unsigned occ_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_lce_p-1:0]               req_v_i,
  input  logic [num_lce_p-1:0]               req_ready_then_i,
  input  logic [num_lce_p*paddr_width_p-1:0] req_addr_i,
  input  logic [num_lce_p-1:0]               cmd_v_i,
  input  logic [num_lce_p-1:0]               cmd_yumi_i,
  input  logic [num_lce_p-1:0]               cmd_complete_i,
  input  logic [num_lce_p*paddr_width_p-1:0] cmd_addr_i,
  output logic [num_lce_p*occ_width_lp-1:0]  outstanding_o,
  output logic [ctr_width_p-1:0]             req_count_o,
  output logic [ctr_width_p-1:0]             cmp_count_o,
  output logic [num_lce_p-1:0]               err_overflow_o,
  output logic [num_lce_p-1:0]               err_dup_o,
  output logic [num_lce_p-1:0]               err_orphan_o,
  output logic [num_lce_p-1:0]               err_timeout_o,
  output logic                               err_any_o
);

  localparam int unsigned offset_lp    = $clog2(block_width_p / 8);
  localparam int unsigned blk_width_lp = paddr_width_p - offset_lp;
  localparam int unsigned age_width_lp = $clog2(timeout_p + 1);

  typedef enum logic {StEmpty, StPending} entry_state_e;

  entry_state_e            state_q [num_lce_p][max_outstanding_p];
  entry_state_e            state_d [num_lce_p][max_outstanding_p];
  logic [blk_width_lp-1:0] blk_q   [num_lce_p][max_outstanding_p];
  logic [blk_width_lp-1:0] blk_d   [num_lce_p][max_outstanding_p];
  logic [age_width_lp-1:0] age_q   [num_lce_p][max_outstanding_p];
  logic [age_width_lp-1:0] age_d   [num_lce_p][max_outstanding_p];

  logic [max_outstanding_p-1:0] rel   [num_lce_p];
  logic [max_outstanding_p-1:0] alloc [num_lce_p];
  logic [blk_width_lp-1:0]      req_blk [num_lce_p];
  logic [blk_width_lp-1:0]      cmp_blk [num_lce_p];
  logic [occ_width_lp-1:0]      occ     [num_lce_p];

  logic [num_lce_p-1:0] req_ev, cmp_ev;
  logic [num_lce_p-1:0] ovf_ev, dup_ev, orphan_ev, timeout_ev;
  logic [num_lce_p-1:0] err_overflow_q, err_dup_q, err_orphan_q, err_timeout_q;
  logic [ctr_width_p-1:0] req_count_q, req_count_d, cmp_count_q, cmp_count_d;
  logic hit, free;

  // Only the block-number bits take part in matching.
  logic unused_addr;
  assign unused_addr = ^{req_addr_i, cmd_addr_i};

  // Decode handshakes and extract block addresses per LCE
  always_comb begin
    for (int i = 0; i < num_lce_p; i++) begin
      req_ev[i]  = req_v_i[i] & req_ready_then_i[i];
      cmp_ev[i]  = cmd_v_i[i] & cmd_yumi_i[i] & cmd_complete_i[i];
      req_blk[i] = req_addr_i[i*paddr_width_p + offset_lp +: blk_width_lp];
      cmp_blk[i] = cmd_addr_i[i*paddr_width_p + offset_lp +: blk_width_lp];
    end
  end

  // Table next state: release first, then allocate (a released slot is reusable this cycle)
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    age_d       = age_q;
    req_count_d = req_count_q;
    cmp_count_d = cmp_count_q;
    ovf_ev      = '0;
    dup_ev      = '0;
    orphan_ev   = '0;
    timeout_ev  = '0;
    hit         = 1'b0;
    free        = 1'b0;
    for (int i = 0; i < num_lce_p; i++) begin
      rel[i]   = '0;
      alloc[i] = '0;
      hit      = 1'b0;
      free     = 1'b0;
      if (cmp_ev[i]) begin
        for (int j = 0; j < max_outstanding_p; j++) begin
          if (!hit && state_q[i][j] == StPending && blk_q[i][j] == cmp_blk[i]) begin
            hit       = 1'b1;
            rel[i][j] = 1'b1;
          end
        end
        if (hit) cmp_count_d = cmp_count_d + ctr_width_p'(1);
        else     orphan_ev[i] = 1'b1;
      end
      if (req_ev[i]) begin
        req_count_d = req_count_d + ctr_width_p'(1);
        for (int j = 0; j < max_outstanding_p; j++) begin
          if (state_q[i][j] == StPending && !rel[i][j] && blk_q[i][j] == req_blk[i]) begin
            dup_ev[i] = 1'b1;
          end
        end
        for (int j = 0; j < max_outstanding_p; j++) begin
          if (!free && (state_q[i][j] == StEmpty || rel[i][j])) begin
            free        = 1'b1;
            alloc[i][j] = 1'b1;
          end
        end
        ovf_ev[i] = ~free;
      end
      for (int j = 0; j < max_outstanding_p; j++) begin
        if (state_q[i][j] == StPending && age_q[i][j] == age_width_lp'(timeout_p)) begin
          timeout_ev[i] = 1'b1;
        end
        if (alloc[i][j]) begin
          state_d[i][j] = StPending;
          blk_d[i][j]   = req_blk[i];
          age_d[i][j]   = '0;
        end else if (rel[i][j]) begin
          state_d[i][j] = StEmpty;
        end else if (state_q[i][j] == StPending && age_q[i][j] != age_width_lp'(timeout_p)) begin
          age_d[i][j] = age_q[i][j] + age_width_lp'(1);
        end
      end
    end
  end

  // State registers; reset clears the table immediately
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_lce_p; i++) begin
        for (int j = 0; j < max_outstanding_p; j++) begin
          state_q[i][j] <= StEmpty;
          blk_q[i][j]   <= '0;
          age_q[i][j]   <= '0;
        end
      end
      req_count_q    <= '0;
      cmp_count_q    <= '0;
      err_overflow_q <= '0;
      err_dup_q      <= '0;
      err_orphan_q   <= '0;
      err_timeout_q  <= '0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      age_q          <= age_d;
      req_count_q    <= req_count_d;
      cmp_count_q    <= cmp_count_d;
      err_overflow_q <= err_overflow_q | ovf_ev;
      err_dup_q      <= err_dup_q | dup_ev;
      err_orphan_q   <= err_orphan_q | orphan_ev;
      err_timeout_q  <= err_timeout_q | timeout_ev;
    end
  end

  // Per-LCE occupancy from the registered table
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < num_lce_p; i++) begin
      occ[i] = '0;
      for (int j = 0; j < max_outstanding_p; j++) begin
        if (state_q[i][j] == StPending) occ[i] = occ[i] + occ_width_lp'(1);
      end
      outstanding_o[i*occ_width_lp +: occ_width_lp] = occ[i];
    end
  end

  assign req_count_o    = req_count_q;
  assign cmp_count_o    = cmp_count_q;
  assign err_overflow_o = err_overflow_q;
  assign err_dup_o      = err_dup_q;
  assign err_orphan_o   = err_orphan_q;
  assign err_timeout_o  = err_timeout_q;
  assign err_any_o      = |{err_overflow_q, err_dup_q, err_orphan_q, err_timeout_q};

`ifdef BP_ME_LCE_TXN_MONITOR_TRACE_EN
  // Log every table event once out of reset
  always @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < num_lce_p; i++) begin
        for (int j = 0; j < max_outstanding_p; j++) begin
          if (rel[i][j])
            $display("%0t lce=%0d release entry=%0d blk=%h age=%0d",
                     $time, i, j, blk_q[i][j], age_q[i][j]);
          if (alloc[i][j])
            $display("%0t lce=%0d alloc entry=%0d blk=%h age=0",
                     $time, i, j, req_blk[i]);
        end
        if (ovf_ev[i]) begin
          $display("%0t lce=%0d overflow entry=- blk=%h", $time, i, req_blk[i]);
          if (!err_overflow_q[i]) $error("lce %0d: request with table full", i);
        end
        if (dup_ev[i]) begin
          $display("%0t lce=%0d duplicate entry=- blk=%h", $time, i, req_blk[i]);
          if (!err_dup_q[i]) $error("lce %0d: duplicate outstanding block", i);
        end
        if (orphan_ev[i]) begin
          $display("%0t lce=%0d orphan entry=- blk=%h", $time, i, cmp_blk[i]);
          if (!err_orphan_q[i]) $error("lce %0d: completion without request", i);
        end
        if (timeout_ev[i] && !err_timeout_q[i]) begin
          $display("%0t lce=%0d timeout entry=- blk=-", $time, i);
          $error("lce %0d: outstanding entry timed out", i);
        end
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_bp_me_nonsynth_lce_txn_monitor.sv
// Self-checking bench for bp_me_nonsynth_lce_txn_monitor: directed vectors with literal
// expectations plus a timestamp-based reference model compared on every falling edge.
module tb_bp_me_nonsynth_lce_txn_monitor;

  localparam int Timeout = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [1:0]  req_v, req_rdy, cmd_v, cmd_yumi, cmd_cpl;
  logic [79:0] req_addr, cmd_addr;
  logic [3:0]  outstanding;
  logic [7:0]  req_count, cmp_count;
  logic [1:0]  e_ovf, e_dup, e_orph, e_to;
  logic        e_any;

  int n_vec = 0;
  int n_miss = 0;
  logic chk_en = 1'b0;

  bp_me_nonsynth_lce_txn_monitor #(
    .num_lce_p(2), .paddr_width_p(40), .block_width_p(512),
    .max_outstanding_p(2), .timeout_p(Timeout), .ctr_width_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v), .req_ready_then_i(req_rdy), .req_addr_i(req_addr),
    .cmd_v_i(cmd_v), .cmd_yumi_i(cmd_yumi), .cmd_complete_i(cmd_cpl), .cmd_addr_i(cmd_addr),
    .outstanding_o(outstanding), .req_count_o(req_count), .cmp_count_o(cmp_count),
    .err_overflow_o(e_ovf), .err_dup_o(e_dup), .err_orphan_o(e_orph), .err_timeout_o(e_to),
    .err_any_o(e_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each LCE holds up to two (block, allocation-edge) records.
  int          edge_n = 0;
  logic        m_pend [2][2];
  logic [33:0] m_blk  [2][2];
  int          m_t    [2][2];
  int          m_req, m_cmp;
  logic [1:0]  m_ovf, m_dup, m_orph, m_to;

  function automatic logic [33:0] blk_of(input logic [39:0] a);
    return a[39:6];
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) m_pend[i][j] = 1'b0;
      m_req = 0; m_cmp = 0;
      m_ovf = '0; m_dup = '0; m_orph = '0; m_to = '0;
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        int rel;
        int slot;
        logic [39:0] ra, ca;
        ra = req_addr[i*40 +: 40];
        ca = cmd_addr[i*40 +: 40];
        // Cycles spent pending before this edge; saturation makes >= the right test.
        for (int j = 0; j < 2; j++)
          if (m_pend[i][j] && (edge_n - 1 - m_t[i][j]) >= Timeout) m_to[i] = 1'b1;
        rel = -1;
        if (cmd_v[i] && cmd_yumi[i] && cmd_cpl[i]) begin
          for (int j = 0; j < 2; j++)
            if (rel < 0 && m_pend[i][j] && m_blk[i][j] == blk_of(ca)) rel = j;
          if (rel < 0) m_orph[i] = 1'b1;
          else begin
            m_cmp++;
            m_pend[i][rel] = 1'b0;
          end
        end
        if (req_v[i] && req_rdy[i]) begin
          m_req++;
          for (int j = 0; j < 2; j++)
            if (m_pend[i][j] && m_blk[i][j] == blk_of(ra)) m_dup[i] = 1'b1;
          slot = -1;
          for (int j = 0; j < 2; j++)
            if (slot < 0 && !m_pend[i][j]) slot = j;
          if (slot < 0) m_ovf[i] = 1'b1;
          else begin
            m_pend[i][slot] = 1'b1;
            m_blk[i][slot]  = blk_of(ra);
            m_t[i][slot]    = edge_n;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int cnt;
        cnt = 0;
        for (int j = 0; j < 2; j++) if (m_pend[i][j]) cnt++;
        check("model_outstanding", 32'(outstanding[i*2 +: 2]), cnt);
      end
      check("model_req_count", 32'(req_count), 32'(m_req[7:0]));
      check("model_cmp_count", 32'(cmp_count), 32'(m_cmp[7:0]));
      check("model_err", {24'b0, e_ovf, e_dup, e_orph, e_to}, {24'b0, m_ovf, m_dup, m_orph, m_to});
      check("model_err_any", 32'(e_any), 32'(|{m_ovf, m_dup, m_orph, m_to}));
    end
  end

  task automatic step(input logic [1:0] rv, input logic [39:0] ra0, input logic [39:0] ra1,
                      input logic [1:0] cv, input logic [39:0] ca0, input logic [39:0] ca1);
    req_v = rv; req_rdy = rv; req_addr = {ra1, ra0};
    cmd_v = cv; cmd_yumi = cv; cmd_cpl = cv; cmd_addr = {ca1, ca0};
    @(posedge clk);
    #2;
    req_v = '0; req_rdy = '0; cmd_v = '0; cmd_yumi = '0; cmd_cpl = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 40'h0, 40'h0, 2'b00, 40'h0, 40'h0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
  endtask

  initial begin
    req_v = '0; req_rdy = '0; cmd_v = '0; cmd_yumi = '0; cmd_cpl = '0;
    req_addr = '0; cmd_addr = '0;
    #1 reset_i = 1'b1;
    #1;
    check("reset_outstanding", 32'(outstanding), 0);
    check("reset_counts", {16'b0, req_count, cmp_count}, 0);
    check("reset_err_any", 32'(e_any), 0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    chk_en = 1'b1;

    // Request then matching completion (same 64-byte block) five cycles later
    step(2'b01, 40'h1040, 40'h0, 2'b00, 40'h0, 40'h0);
    check("t1_outstanding_1", 32'(outstanding[1:0]), 1);
    check("t1_req_count", 32'(req_count), 1);
    idle(3);
    // Partial handshakes are not events
    req_v = 2'b01; req_rdy = 2'b00; req_addr = {40'h0, 40'h5000};
    cmd_v = 2'b01; cmd_yumi = 2'b01; cmd_cpl = 2'b00; cmd_addr = {40'h0, 40'h7000};
    @(posedge clk); #2;
    check("t1_partial_counts", {16'b0, req_count, cmp_count}, 32'h0100);
    check("t1_partial_err", 32'(e_any), 0);
    step(2'b00, 40'h0, 40'h0, 2'b01, 40'h1078, 40'h0);
    check("t1_outstanding_0", 32'(outstanding[1:0]), 0);
    check("t1_cmp_count", 32'(cmp_count), 1);
    check("t1_no_err", 32'(e_any), 0);

    // Overflow on LCE1
    do_reset();
    step(2'b10, 40'h0, 40'h000, 2'b00, 40'h0, 40'h0);
    step(2'b10, 40'h0, 40'h040, 2'b00, 40'h0, 40'h0);
    step(2'b10, 40'h0, 40'h080, 2'b00, 40'h0, 40'h0);
    check("t2_overflow", 32'(e_ovf), 2);
    check("t2_outstanding", 32'(outstanding[3:2]), 2);
    check("t2_req_count", 32'(req_count), 3);

    // Orphan completion
    do_reset();
    step(2'b00, 40'h0, 40'h0, 2'b01, 40'h2000, 40'h0);
    check("t3_orphan", 32'(e_orph), 1);
    check("t3_cmp_count", 32'(cmp_count), 0);
    check("t3_err_any", 32'(e_any), 1);

    // Timeout at 16
    do_reset();
    step(2'b01, 40'h3000, 40'h0, 2'b00, 40'h0, 40'h0);
    idle(15);
    check("t4_timeout_15", 32'(e_to), 0);
    idle(1);
    check("t4_timeout_16", 32'(e_to), 0);
    idle(1);
    check("t4_timeout_17", 32'(e_to), 1);
    check("t4_still_pending", 32'(outstanding[1:0]), 1);

    // Duplicate on LCE1; full LCE0 with same-cycle release and reallocate
    do_reset();
    step(2'b11, 40'h000, 40'h100, 2'b00, 40'h0, 40'h0);
    step(2'b11, 40'h040, 40'h120, 2'b00, 40'h0, 40'h0);
    check("t5_dup", 32'(e_dup), 2);
    check("t5_outstanding_full", 32'(outstanding), 32'hA);
    step(2'b01, 40'h000, 40'h0, 2'b01, 40'h000, 40'h0);
    check("t5_outstanding_same", 32'(outstanding[1:0]), 2);
    check("t5_no_ovf", 32'(e_ovf), 0);
    check("t5_dup_unchanged", 32'(e_dup), 2);
    check("t5_counts", {16'b0, req_count, cmp_count}, 32'h0501);

    // Asynchronous reset between edges with two live entries
    do_reset();
    step(2'b01, 40'h000, 40'h0, 2'b00, 40'h0, 40'h0);
    step(2'b01, 40'h040, 40'h0, 2'b00, 40'h0, 40'h0);
    check("t6_live", 32'(outstanding), 2);
    #1 reset_i = 1'b1;
    #1;
    check("t6_async_outstanding", 32'(outstanding), 0);
    check("t6_async_req_count", 32'(req_count), 0);
    reset_i = 1'b0;
    step(2'b00, 40'h0, 40'h0, 2'b01, 40'h040, 40'h0);
    check("t6_orphan", 32'(e_orph), 1);
    check("t6_cmp_count", 32'(cmp_count), 0);

    // Both LCEs every cycle; 8-bit counters wrap after 256
    do_reset();
    for (int k = 0; k < 130; k++) begin
      step(2'b11, 40'(k * 64), 40'(32'h10000 + k * 64), 2'b00, 40'h0, 40'h0);
      step(2'b00, 40'h0, 40'h0, 2'b11, 40'(k * 64), 40'(32'h10000 + k * 64));
    end
    check("t7_req_wrap", 32'(req_count), 4);
    check("t7_cmp_wrap", 32'(cmp_count), 4);
    step(2'b11, 40'h8000, 40'h9000, 2'b00, 40'h0, 40'h0);
    step(2'b11, 40'h8400, 40'h9400, 2'b11, 40'h8000, 40'h9000);
    check("t7_outstanding", 32'(outstanding), 32'h5);
    check("t7_counts", {16'b0, req_count, cmp_count}, 32'h0806);
    check("t7_no_err", 32'(e_any), 0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
